// File: rtl/writeback_unit.sv
// Register-file write port: ALU/load arbitration, load queue, load scoreboard.
// Optional WB_LOAD_EXTEND_EN aligns and sign/zero-extends load data.
module writeback_unit #(
  parameter  int REG_COUNT = 16,
  parameter  int LQ_DEPTH  = 2,
  localparam int CW        = $clog2(LQ_DEPTH + 1),
  localparam int PW        = $clog2(LQ_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          ld_issue,
  input  logic [4:0]    ld_issue_rd,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [4:0]    ld_rd,
  input  logic [31:0]   ld_data,
  input  logic [2:0]    ld_funct3,
  input  logic [1:0]    ld_byte_off,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic          hazard,
  output logic [4:0]    address_3,
  output logic [31:0]   write_data,
  output logic          write_enable,
  output logic [CW-1:0] lq_count
);

  logic [4:0]           r_q_rd   [LQ_DEPTH];
  logic [31:0]          r_q_data [LQ_DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [REG_COUNT-1:0] r_pend;
  logic                 r_we;
  logic                 r_wb_ld;
  logic [4:0]           r_addr;
  logic [31:0]          r_data;

  logic                 w_alu_ok;
  logic                 w_accept;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_drain;
  logic                 w_lc_go;
  logic [4:0]           w_lc_rd;
  logic [31:0]          w_lc_data;
  logic                 w_lc_ok;
  logic [31:0]          w_ld_word;
  logic [REG_COUNT-1:0] w_set;
  logic [REG_COUNT-1:0] w_clr;
  logic                 w_hz;

  function automatic logic rd_ok(input logic [4:0] rd);
    return (rd != 5'd0) && (int'(rd) < REG_COUNT);
  endfunction

`ifdef WB_LOAD_EXTEND_EN
  function automatic logic [31:0] ld_ext(
    input logic [31:0] d,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    unique case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

  assign w_ld_word = ld_ext(ld_data, ld_funct3, ld_byte_off);
`else
  logic w_unused;
  assign w_unused  = ^{ld_funct3, ld_byte_off};
  assign w_ld_word = ld_data;
`endif

  assign ld_ready  = !reset && (r_count < CW'(LQ_DEPTH));
  assign w_alu_ok  = alu_valid && rd_ok(alu_rd);
  assign w_accept  = ld_valid && ld_ready;
  assign w_empty   = (r_count == '0);
  assign w_drain   = !w_alu_ok && !w_empty;
  // Empty queue with no ALU write: accepted load bypasses the queue.
  assign w_push    = w_accept && !(w_empty && !w_alu_ok);
  assign w_lc_go   = !w_alu_ok && (!w_empty || w_accept);
  assign w_lc_rd   = w_empty ? ld_rd : r_q_rd[r_head];
  assign w_lc_data = w_empty ? w_ld_word : r_q_data[r_head];
  assign w_lc_ok   = rd_ok(w_lc_rd);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    w_hz  = 1'b0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (ld_issue && ld_issue_rd == 5'(i))
        w_set[i] = 1'b1;
      if (r_we && r_wb_ld && r_addr == 5'(i))
        w_clr[i] = 1'b1;
      if ((rs1 == 5'(i) || rs2 == 5'(i)) && r_pend[i])
        w_hz = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend  <= '0;
      r_we    <= 1'b0;
      r_wb_ld <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      // Set after clear so a reissue to the same rd stays pending.
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_alu_ok) begin
        r_we    <= 1'b1;
        r_wb_ld <= 1'b0;
        r_addr  <= alu_rd;
        r_data  <= alu_data;
      end else if (w_lc_go) begin
        r_we    <= w_lc_ok;
        r_wb_ld <= w_lc_ok;
        if (w_lc_ok) begin
          r_addr <= w_lc_rd;
          r_data <= w_lc_data;
        end
      end else begin
        r_we    <= 1'b0;
        r_wb_ld <= 1'b0;
      end
      if (w_push) begin
        r_q_rd[r_tail]   <= ld_rd;
        r_q_data[r_tail] <= w_ld_word;
        r_tail           <= r_tail + PW'(1);
      end
      if (w_drain)
        r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_drain);
    end
  end

  assign hazard       = w_hz;
  assign address_3    = r_addr;
  assign write_data   = r_data;
  assign write_enable = r_we;
  assign lq_count     = r_count;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic,
// all cycles checked against a queue-based reference model.
module tb_writeback_unit;

  localparam int RC = 16;
  localparam int LQ = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_off;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic [4:0]  address_3;
  logic [31:0] write_data;
  logic        write_enable;
  logic [1:0]  lq_count;

  writeback_unit #(.REG_COUNT(RC), .LQ_DEPTH(LQ)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_byte_off(ld_byte_off),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .address_3(address_3), .write_data(write_data),
    .write_enable(write_enable), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          pend[32];
  logic        m_we;
  logic        m_ld;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit okrd(input logic [4:0] r);
    return r != 0 && int'(r) < RC;
  endfunction

  function automatic logic [31:0] mext(input logic [31:0] d,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
`ifdef WB_LOAD_EXTEND_EN
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
`else
    return d;
`endif
  endfunction

  task automatic model_edge();
    ent_t nw;
    ent_t e;
    bit   acc;
    if (reset) begin
      q.delete();
      foreach (pend[i]) pend[i] = 0;
      m_we = 0; m_ld = 0; m_addr = 0; m_data = 0;
    end else begin
      acc   = ld_valid && q.size() < LQ;
      nw.rd = ld_rd;
      nw.d  = mext(ld_data, ld_funct3, ld_byte_off);
      if (m_we && m_ld) pend[m_addr] = 0;
      if (ld_issue && okrd(ld_issue_rd)) pend[ld_issue_rd] = 1;
      if (alu_valid && okrd(alu_rd)) begin
        m_we = 1; m_ld = 0; m_addr = alu_rd; m_data = alu_data;
        if (acc) q.push_back(nw);
      end else if (q.size() > 0 || acc) begin
        if (acc) q.push_back(nw);
        e = q.pop_front();
        m_we = okrd(e.rd);
        m_ld = m_we;
        if (m_we) begin
          m_addr = e.rd;
          m_data = e.d;
        end
      end else begin
        m_we = 0; m_ld = 0;
      end
    end
  endtask

  task automatic check_all();
    bit hz;
    hz = (rs1 != 0 && pend[rs1]) || (rs2 != 0 && pend[rs2]);
    chk("we", 32'(write_enable), 32'(m_we));
    chk("addr", 32'(address_3), 32'(m_addr));
    chk("data", write_data, m_data);
    chk("lq_count", 32'(lq_count), 32'(q.size()));
    chk("ld_ready", 32'(ld_ready), 32'(!reset && q.size() < LQ));
    chk("hazard", 32'(hazard), 32'(hz));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    ld_funct3 = 3'b010; ld_byte_off = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic ld_resp(input logic [4:0] rd, input logic [31:0] d,
                         input logic [2:0] f3, input logic [1:0] off);
    ld_valid = 1; ld_rd = rd; ld_data = d;
    ld_funct3 = f3; ld_byte_off = off;
  endtask

  logic [31:0] exp_lb, exp_lbu, exp_lh;

  initial begin
    idle();
    reset = 1;
    m_we = 0; m_ld = 0; m_addr = 0; m_data = 0;
    cycle();
    cycle();
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_addr", 32'(address_3), 0);
    chk("rst_data", write_data, 0);
    chk("rst_ready", 32'(ld_ready), 0);
    reset = 0;

    // ALU write then rd 0
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("alu_we", 32'(write_enable), 1);
    chk("alu_addr", 32'(address_3), 5);
    chk("alu_data", write_data, 32'hDEADBEEF);
    alu_rd = 0;
    cycle();
    chk("alu_rd0_we", 32'(write_enable), 0);

    // Load hazard on rd 7
    idle();
    ld_issue = 1; ld_issue_rd = 7; rs1 = 7;
    cycle();
    chk("hz_set", 32'(hazard), 1);
    ld_issue = 0;
    ld_resp(7, 32'h12345678, 3'b010, 0);
    cycle();
    chk("ld7_we", 32'(write_enable), 1);
    chk("ld7_addr", 32'(address_3), 7);
    chk("ld7_data", write_data, 32'h12345678);
    chk("hz_hold", 32'(hazard), 1);
    ld_valid = 0;
    cycle();
    chk("hz_clr", 32'(hazard), 0);

    // Two loads queued behind a three-cycle ALU burst
    idle();
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA;
    ld_resp(3, 32'h33, 3'b010, 0);
    cycle();
    alu_rd = 11; alu_data = 32'hB;
    ld_resp(4, 32'h44, 3'b010, 0);
    cycle();
    chk("full_cnt", 32'(lq_count), 2);
    chk("full_rdy", 32'(ld_ready), 0);
    ld_valid = 0; alu_rd = 12; alu_data = 32'hC;
    cycle();
    chk("full_rdy2", 32'(ld_ready), 0);
    idle();
    cycle();
    chk("drain3", 32'(address_3), 3);
    chk("drain3_rdy", 32'(ld_ready), 1);
    cycle();
    chk("drain4", 32'(address_3), 4);
    chk("drain4_we", 32'(write_enable), 1);

    // Reissue rd 9 in the cycle its previous load writes
    idle();
    ld_issue = 1; ld_issue_rd = 9;
    cycle();
    ld_issue = 0;
    ld_resp(9, 32'h99, 3'b010, 0);
    cycle();
    idle();
    ld_issue = 1; ld_issue_rd = 9; rs1 = 9;
    cycle();
    chk("set_wins", 32'(hazard), 1);
    idle();
    rs2 = 9;
    ld_resp(9, 32'h999, 3'b010, 0);
    cycle();
    ld_valid = 0;
    cycle();
    chk("rd9_clr", 32'(hazard), 0);

    // Load alignment / extension
`ifdef WB_LOAD_EXTEND_EN
    exp_lb = 32'hFFFFFF80; exp_lbu = 32'h00000080; exp_lh = 32'hFFFF80FF;
`else
    exp_lb = 32'h80FF7F01; exp_lbu = 32'h80FF7F01; exp_lh = 32'h80FF7F01;
`endif
    idle();
    ld_resp(6, 32'h80FF7F01, 3'b000, 3);
    cycle();
    chk("lb3", write_data, exp_lb);
    ld_resp(6, 32'h80FF7F01, 3'b100, 3);
    cycle();
    chk("lbu3", write_data, exp_lbu);
    ld_resp(6, 32'h80FF7F01, 3'b001, 2);
    cycle();
    chk("lh2", write_data, exp_lh);

    // Reset with two queued loads and three pending bits
    idle();
    for (int r = 1; r <= 3; r++) begin
      ld_issue = 1; ld_issue_rd = 5'(r);
      cycle();
    end
    ld_issue = 0;
    alu_valid = 1; alu_rd = 10; alu_data = 32'h1;
    ld_resp(1, 32'h111, 3'b010, 0);
    cycle();
    ld_resp(2, 32'h222, 3'b010, 0);
    cycle();
    chk("pre_rst_cnt", 32'(lq_count), 2);
    idle();
    rs1 = 1; rs2 = 3;
    reset = 1;
    cycle();
    chk("rst_cnt", 32'(lq_count), 0);
    chk("rst_hz", 32'(hazard), 0);
    chk("rst_we2", 32'(write_enable), 0);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("post_rst_we", 32'(write_enable), 0);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      alu_valid   = $urandom_range(0, 9) < 4;
      alu_rd      = 5'($urandom_range(0, 17));
      alu_data    = $urandom;
      ld_issue    = $urandom_range(0, 2) == 0;
      ld_issue_rd = 5'($urandom_range(0, 17));
      ld_valid    = $urandom_range(0, 9) < 6;
      ld_rd       = 5'($urandom_range(0, 17));
      ld_data     = $urandom;
      ld_funct3   = 3'($urandom_range(0, 7));
      ld_byte_off = 2'($urandom_range(0, 3));
      rs1         = 5'($urandom_range(0, 15));
      rs2         = 5'($urandom_range(0, 15));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
